// File: rtl/ucsbece154b_fetch_queue.sv
// Dual-issue fetch queue: buffers aligned {PC, PC+4} pairs from fetch and presents the two oldest entries to decode.
// Latency: a pair pushed at edge N appears on the slot outputs after edge N; slot reads are combinational from storage.
// Backpressure: fetch_ready_o drops when fewer than two entries are free; decode retires 0/1/2 entries via stall_i/issue2_i.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset (same effect as flush)
//   fetch_*             pair input from fetch; fetch_ready_o = at least two free entries
//   slot1_* / slot2_*   head and head+1 entries; NOP (0x00000013) and PC 0 when not valid
//   stall_i, issue2_i   decode retire control: stall retires nothing, issue2_i retires two if available
//   flush_i             discard everything, including any same-cycle push and pop
//   count_o             current occupancy (PTR_W+1 bits)

module ucsbece154b_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid_i,
    input  logic [31:0]      fetch_pc_i,
    input  logic [31:0]      fetch_instr0_i,
    input  logic [31:0]      fetch_instr1_i,
    output logic             fetch_ready_o,
    output logic             slot1_valid_o,
    output logic [31:0]      slot1_instr_o,
    output logic [31:0]      slot1_pc_o,
    output logic             slot2_valid_o,
    output logic [31:0]      slot2_instr_o,
    output logic [31:0]      slot2_pc_o,
    input  logic             stall_i,
    input  logic             issue2_i,
    input  logic             flush_i,
    output logic [PTR_W:0]   count_o
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [31:0]    NOP_INSTR = 32'h0000_0013;
    // Highest occupancy that still leaves room for a whole pair.
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [PTR_W-1:0] head1Ptr;
    logic [PTR_W-1:0] tail1Ptr;
    logic [PTR_W:0]   countQ;
    logic [PTR_W:0]   countNext;
    logic             push;
    logic [1:0]       popCnt;
    entry_t           headEntry;
    entry_t           head1Entry;

    // Status comes only from the registered count, so decode-side controls
    // never have a combinational path back to fetch_ready_o or the valids.
    assign slot1_valid_o = (countQ != '0);
    assign slot2_valid_o = (countQ >= (PTR_W+1)'(2));
    assign fetch_ready_o = (countQ <= READY_MAX);
    assign count_o       = countQ;

    assign push     = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign head1Ptr = headPtr + PTR_W'(1);
    assign tail1Ptr = tailPtr + PTR_W'(1);

    // Retire count; issue2_i with a single valid entry still only retires one.
    always_comb begin
        popCnt = 2'd0;
        if (!stall_i && slot1_valid_o) begin
            popCnt = (issue2_i && slot2_valid_o) ? 2'd2 : 2'd1;
        end
    end

    // Cannot overflow: push only happens with count <= DEPTH-2.
    assign countNext = countQ
                     + (push ? (PTR_W+1)'(2) : (PTR_W+1)'(0))
                     - (PTR_W+1)'(popCnt);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
        end else begin
            headPtr <= headPtr + PTR_W'(popCnt);
            if (push) begin
                tailPtr <= tailPtr + PTR_W'(2);
            end
            countQ <= countNext;
        end
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[tailPtr]  <= '{pc: fetch_pc_i,             instr: fetch_instr0_i};
            mem[tail1Ptr] <= '{pc: fetch_pc_i + 32'd4,     instr: fetch_instr1_i};
        end
    end

    assign headEntry  = mem[headPtr];
    assign head1Entry = mem[head1Ptr];

    assign slot1_instr_o = slot1_valid_o ? headEntry.instr  : NOP_INSTR;
    assign slot1_pc_o    = slot1_valid_o ? headEntry.pc     : 32'd0;
    assign slot2_instr_o = slot2_valid_o ? head1Entry.instr : NOP_INSTR;
    assign slot2_pc_o    = slot2_valid_o ? head1Entry.pc    : 32'd0;

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// Testbench for ucsbece154b_fetch_queue: queue-based reference model checked every cycle,
// plus hand-computed expectations for reset, pair, split issue, full, flush and wrap cases.

module tb_ucsbece154b_fetch_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             fetch_valid_i;
    logic [31:0]      fetch_pc_i;
    logic [31:0]      fetch_instr0_i;
    logic [31:0]      fetch_instr1_i;
    logic             fetch_ready_o;
    logic             slot1_valid_o;
    logic [31:0]      slot1_instr_o;
    logic [31:0]      slot1_pc_o;
    logic             slot2_valid_o;
    logic [31:0]      slot2_instr_o;
    logic [31:0]      slot2_pc_o;
    logic             stall_i;
    logic             issue2_i;
    logic             flush_i;
    logic [PTR_W:0]   count_o;

    int nCmp = 0;
    int nErr = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    ucsbece154b_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
        .fetch_instr0_i(fetch_instr0_i), .fetch_instr1_i(fetch_instr1_i),
        .fetch_ready_o(fetch_ready_o),
        .slot1_valid_o(slot1_valid_o), .slot1_instr_o(slot1_instr_o), .slot1_pc_o(slot1_pc_o),
        .slot2_valid_o(slot2_valid_o), .slot2_instr_o(slot2_instr_o), .slot2_pc_o(slot2_pc_o),
        .stall_i(stall_i), .issue2_i(issue2_i), .flush_i(flush_i),
        .count_o(count_o)
    );

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered list of {pc, instr}.
    logic [63:0] mq[$];

    always @(posedge clk) begin
        int sz;
        int pop;
        bit pushOk;
        sz = mq.size();
        if (reset || flush_i) begin
            mq.delete();
        end else begin
            pop = 0;
            if (!stall_i && sz >= 1) pop = (issue2_i && sz >= 2) ? 2 : 1;
            pushOk = fetch_valid_i && (DEPTH - sz >= 2);
            for (int k = 0; k < pop; k++) void'(mq.pop_front());
            if (pushOk) begin
                mq.push_back({fetch_pc_i, fetch_instr0_i});
                mq.push_back({fetch_pc_i + 32'd4, fetch_instr1_i});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            int sz;
            sz = mq.size();
            chk("m_count",  32'(count_o),       32'(sz));
            chk("m_ready",  32'(fetch_ready_o), 32'(DEPTH - sz >= 2));
            chk("m_s1v",    32'(slot1_valid_o), 32'(sz >= 1));
            chk("m_s2v",    32'(slot2_valid_o), 32'(sz >= 2));
            chk("m_s1pc",   slot1_pc_o,    (sz >= 1) ? mq[0][63:32] : 32'd0);
            chk("m_s1ins",  slot1_instr_o, (sz >= 1) ? mq[0][31:0]  : 32'h13);
            chk("m_s2pc",   slot2_pc_o,    (sz >= 2) ? mq[1][63:32] : 32'd0);
            chk("m_s2ins",  slot2_instr_o, (sz >= 2) ? mq[1][31:0]  : 32'h13);
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic fv, input logic [31:0] pc,
                       input logic st, input logic is2, input logic fl);
        fetch_valid_i  = fv;
        fetch_pc_i     = pc;
        fetch_instr0_i = instrOf(pc);
        fetch_instr1_i = instrOf(pc + 32'd4);
        stall_i        = st;
        issue2_i       = is2;
        flush_i        = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] expPc;
        reset = 1'b1;
        fetch_valid_i = 1'b0; fetch_pc_i = '0; fetch_instr0_i = '0; fetch_instr1_i = '0;
        stall_i = 1'b0; issue2_i = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;
        checkEn = 1'b1;
        @(posedge clk); #1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_s1v",   32'(slot1_valid_o), 0);
        chk("rst_s2v",   32'(slot2_valid_o), 0);
        chk("rst_s1ins", slot1_instr_o, 32'h13);
        chk("rst_s2ins", slot2_instr_o, 32'h13);
        chk("rst_s1pc",  slot1_pc_o, 0);
        chk("rst_ready", 32'(fetch_ready_o), 1);
        reset = 1'b0;

        // Single pair, then dual issue drains it.
        cyc(1, 32'h100, 0, 0, 0);
        chk("pair_s1pc",  slot1_pc_o, 32'h100);
        chk("pair_s1ins", slot1_instr_o, instrOf(32'h100));
        chk("pair_s2pc",  slot2_pc_o, 32'h104);
        chk("pair_s2ins", slot2_instr_o, instrOf(32'h104));
        cyc(0, 0, 0, 1, 0);
        chk("pair_drain", 32'(count_o), 0);

        // Split issue: second push coincides with a single retire.
        cyc(1, 32'h100, 0, 0, 0);
        cyc(1, 32'h108, 0, 0, 0);
        chk("split_s1pc",  slot1_pc_o, 32'h104);
        chk("split_s2pc",  slot2_pc_o, 32'h108);
        chk("split_s2ins", slot2_instr_o, instrOf(32'h108));
        chk("split_count", 32'(count_o), 3);
        cyc(0, 0, 0, 0, 1);
        chk("split_flush", 32'(count_o), 0);

        // Fill to DEPTH, hold a fifth pair, then one dual retire.
        for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i * 8), 1, 0, 0);
        chk("full_count", 32'(count_o), 8);
        chk("full_ready", 32'(fetch_ready_o), 0);
        cyc(1, 32'h220, 1, 0, 0);
        chk("full_held", 32'(count_o), 8);
        cyc(1, 32'h220, 0, 1, 0);
        chk("full_pop2_count", 32'(count_o), 6);
        chk("full_pop2_ready", 32'(fetch_ready_o), 1);
        chk("full_pop2_s1pc",  slot1_pc_o, 32'h208);

        // Flush with simultaneous push and pop discards everything.
        cyc(1, 32'h300, 0, 1, 1);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_s1v",   32'(slot1_valid_o), 0);
        chk("flush_s1ins", slot1_instr_o, 32'h13);
        cyc(0, 0, 0, 0, 0);
        chk("flush_absent", 32'(count_o), 0);

        // Stall blocks retire even with issue2_i.
        cyc(1, 32'h400, 0, 0, 0);
        cyc(1, 32'h408, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("stall_count", 32'(count_o), 4);
        chk("stall_s1pc",  slot1_pc_o, 32'h400);
        chk("stall_s2pc",  slot2_pc_o, 32'h404);

        // Steady push2/pop2 across pointer wrap keeps strict +4 order.
        expPc = 32'h400;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h410 + 32'(i * 8), 0, 1, 0);
            expPc = expPc + 32'd8;
            chk("wrap_s1pc", slot1_pc_o, expPc);
            chk("wrap_s2pc", slot2_pc_o, expPc + 32'd4);
        end
        chk("wrap_count", 32'(count_o), 4);

        // Drain, including an issue2 with only one entry left.
        cyc(0, 0, 0, 0, 0);
        chk("drain1_count", 32'(count_o), 3);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("drain_last", 32'(count_o), 0);
        cyc(0, 0, 0, 1, 0);
        chk("pop_empty", 32'(count_o), 0);

        // Reset mid-operation drops entries.
        cyc(1, 32'h500, 0, 0, 0);
        reset = 1'b1;
        cyc(1, 32'h508, 0, 0, 0);
        reset = 1'b0;
        chk("midrst_count", 32'(count_o), 0);
        chk("midrst_s1pc",  slot1_pc_o, 0);

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
